// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bank target.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      REG_ADDR,
      REG_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_state_e;

   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;
   localparam int   BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one open-drain bus line into clk, rejects glitches shorter
// than FILTER_LEN samples and flags accepted rising/falling edges.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    sync_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Two-flop synchronizer; idle bus level is high.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], line_i};
   end

   // Count consecutive samples that disagree with the accepted level; flip
   // the level once FILTER_LEN of them have been seen in a row.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync_q[1];
            rise_d  = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Filter state and one-cycle edge strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target exposing an 8-bit register bank: device address, register
// pointer, then data bytes with auto-increment for both writes and reads.
// The DEV_ADDR parameter shares its name with a state, so states are
// referenced through the package scope.
module i2c_reg_slave #(
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic       reg_wr_en,
   output logic [7:0] reg_wdata,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(clk), .rst(rst), .line_i(scl_in),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(clk), .rst(rst), .line_i(sda_in),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   i2c_pkg::i2c_state_e state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       sda_oe_q, sda_oe_d;
   logic       wr_en_q, wr_en_d;
   logic       rd_en_q, rd_en_d;
   logic       busy_q, busy_d;
   logic       rw_q, rw_d;

   logic start_c, stop_c, rx_state, byte_done;

   assign start_c   = sda_fall & scl_lvl;
   assign stop_c    = sda_rise & scl_lvl;
   assign rx_state  = (state_q == i2c_pkg::DEV_ADDR) || (state_q == i2c_pkg::REG_ADDR) ||
                      (state_q == i2c_pkg::WR_DATA);
   assign byte_done = scl_fall && (bit_cnt_q == 4'(i2c_pkg::BYTE_BITS));

   // Next-state logic: bus conditions first, then per-state bit handling.
   // SDA drive only ever changes on an SCL falling edge.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sda_oe_d  = sda_oe_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      busy_d    = busy_q;
      rw_d      = rw_q;

      if (stop_c) begin
         state_d   = i2c_pkg::IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (start_c) begin
         state_d   = i2c_pkg::DEV_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         if (rx_state && scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end

         case (state_q)
            i2c_pkg::DEV_ADDR: begin
               if (byte_done) begin
                  bit_cnt_d = '0;
                  if (shift_q[7:1] == DEV_ADDR) begin
                     state_d  = i2c_pkg::DEV_ACK;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     rw_d     = shift_q[0];
                  end else begin
                     state_d  = i2c_pkg::IGNORE;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            i2c_pkg::DEV_ACK: begin
               if (scl_rise && rw_q) rd_en_d = 1'b1;
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     shift_d  = reg_rdata;
                     sda_oe_d = ~reg_rdata[7];
                     state_d  = i2c_pkg::RD_DATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = i2c_pkg::REG_ADDR;
                  end
               end
            end
            i2c_pkg::REG_ADDR: begin
               if (byte_done) begin
                  bit_cnt_d = '0;
                  addr_d    = shift_q;
                  sda_oe_d  = 1'b1;
                  state_d   = i2c_pkg::REG_ACK;
               end
            end
            i2c_pkg::REG_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = i2c_pkg::WR_DATA;
               end
            end
            i2c_pkg::WR_DATA: begin
               if (byte_done) begin
                  bit_cnt_d = '0;
                  wdata_d   = shift_q;
                  wr_en_d   = 1'b1;
                  sda_oe_d  = 1'b1;
                  state_d   = i2c_pkg::WR_ACK;
               end
            end
            i2c_pkg::WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  addr_d   = addr_q + 8'd1;
                  state_d  = i2c_pkg::WR_DATA;
               end
            end
            i2c_pkg::RD_DATA: begin
               if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
               if (byte_done) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
                  state_d   = i2c_pkg::RD_ACK;
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            i2c_pkg::RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == i2c_pkg::I2C_ACK) begin
                     addr_d  = addr_q + 8'd1;
                     rd_en_d = 1'b1;
                  end else begin
                     state_d = i2c_pkg::IGNORE;
                  end
               end else if (scl_fall) begin
                  // Only reachable after the master acknowledged.
                  bit_cnt_d = '0;
                  shift_d   = reg_rdata;
                  sda_oe_d  = ~reg_rdata[7];
                  state_d   = i2c_pkg::RD_DATA;
               end
            end
            i2c_pkg::IGNORE: sda_oe_d = 1'b0;
            i2c_pkg::IDLE:   sda_oe_d = 1'b0;
            default:         state_d  = i2c_pkg::IDLE;
         endcase
      end
   end

   // State and output registers; reset releases SDA immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= i2c_pkg::IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         sda_oe_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         rw_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         sda_oe_q  <= sda_oe_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         rw_q      <= rw_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = addr_q;
   assign reg_wr_en = wr_en_q;
   assign reg_wdata = wdata_q;
   assign reg_rd_en = rd_en_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: a bit-banged I2C master drives the target through write,
// mismatch, read, aborted-write, glitch and mid-transfer reset scenarios.
module tb_i2c_reg_slave;
   import i2c_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_line;
   logic       sda_oe, reg_wr_en, reg_rd_en, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;

   int checks = 0;
   int errors = 0;
   int q = 12;

   logic       ack;
   logic [7:0] rd;

   // Open-drain bus: target pulls low when sda_oe is set.
   assign sda_line  = sda_m & ~sda_oe;
   // Register model: read data is the pointer XOR 0x5A.
   assign reg_rdata = reg_addr ^ 8'h5A;

   always #10 clk = ~clk;

   i2c_reg_slave #(.DEV_ADDR(7'h1A), .FILTER_LEN(3)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
      .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
      .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
      .busy(busy)
   );

   // Event monitors (cumulative; tests compare deltas).
   int          wr_cnt = 0, rd_cnt = 0, oe_cyc = 0, start_cnt = 0;
   logic [15:0] wr_log [0:31];
   i2c_state_e  prev_st = IDLE;

   always @(negedge clk) begin
      if (reg_wr_en) begin
         if (wr_cnt < 32) wr_log[wr_cnt] <= {reg_addr, reg_wdata};
         wr_cnt <= wr_cnt + 1;
      end
      if (reg_rd_en) rd_cnt <= rd_cnt + 1;
      if (sda_oe) oe_cyc <= oe_cyc + 1;
      if (dut.state_q == DEV_ADDR && prev_st != DEV_ADDR) start_cnt <= start_cnt + 1;
      prev_st <= dut.state_q;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // START from idle or repeated START from SCL low; leaves SCL low.
   task automatic i2c_start();
      sda_m = 1'b1; tick(q);
      scl_m = 1'b1; tick(q);
      sda_m = 1'b0; tick(q);
      scl_m = 1'b0; tick(q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(q);
      scl_m = 1'b1; tick(q);
      sda_m = 1'b1; tick(q);
   endtask

   task automatic send_bit(input logic b);
      tick(q); sda_m = b; tick(q);
      scl_m = 1'b1; tick(2*q);
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      tick(q); sda_m = 1'b1; tick(q);
      scl_m = 1'b1; tick(q);
      a = sda_line; tick(q);
      scl_m = 1'b0;
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         tick(q); sda_m = 1'b1; tick(q);
         scl_m = 1'b1; tick(q);
         d[i] = sda_line; tick(q);
         scl_m = 1'b0;
      end
      send_bit(ack_bit);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int base_wr, base_rd, base_oe, base_st;

      // Reset state
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      tick(4);
      chk("rst_strobes_oe_busy", {28'd0, sda_oe, reg_wr_en, reg_rd_en, busy}, 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'h00);
      chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      tick(10);

      // Write at 100 kHz (500 clk per bit)
      q = 125;
      base_wr = wr_cnt;
      i2c_start();
      write_byte(8'h34, ack); chk("wr_ack_dev", 32'(ack), 32'd0);
      chk("wr_busy_high", 32'(busy), 32'd1);
      write_byte(8'h05, ack); chk("wr_ack_reg", 32'(ack), 32'd0);
      write_byte(8'hAA, ack); chk("wr_ack_d0", 32'(ack), 32'd0);
      write_byte(8'h55, ack); chk("wr_ack_d1", 32'(ack), 32'd0);
      i2c_stop(); tick(20);
      chk("wr_busy_low", 32'(busy), 32'd0);
      chk("wr_strobe_count", 32'(wr_cnt - base_wr), 32'd2);
      chk("wr_strobe0", 32'(wr_log[base_wr]), 32'h05AA);
      chk("wr_strobe1", 32'(wr_log[base_wr+1]), 32'h0655);
      chk("wr_final_addr", 32'(reg_addr), 32'h07);

      // Address mismatch
      q = 12;
      base_wr = wr_cnt; base_rd = rd_cnt; base_oe = oe_cyc;
      i2c_start();
      write_byte(8'h36, ack); chk("mm_nack_dev", 32'(ack), 32'd1);
      chk("mm_busy", 32'(busy), 32'd0);
      write_byte(8'h05, ack); chk("mm_nack_byte", 32'(ack), 32'd1);
      i2c_stop(); tick(20);
      chk("mm_no_oe", 32'(oe_cyc - base_oe), 32'd0);
      chk("mm_no_wr", 32'(wr_cnt - base_wr), 32'd0);
      chk("mm_no_rd", 32'(rd_cnt - base_rd), 32'd0);
      chk("mm_addr_kept", 32'(reg_addr), 32'h07);

      // Random read with pointer wrap
      base_wr = wr_cnt; base_rd = rd_cnt;
      i2c_start();
      write_byte(8'h34, ack); chk("rd_ack_dev_w", 32'(ack), 32'd0);
      write_byte(8'hFF, ack); chk("rd_ack_ptr", 32'(ack), 32'd0);
      i2c_start();
      write_byte(8'h35, ack); chk("rd_ack_dev_r", 32'(ack), 32'd0);
      read_byte(1'b0, rd);    chk("rd_byte0", 32'(rd), 32'hA5);
      read_byte(1'b1, rd);    chk("rd_byte1", 32'(rd), 32'h5A);
      tick(10);
      chk("rd_sda_released", 32'(sda_oe), 32'd0);
      chk("rd_state_ignore", 32'(dut.state_q), 32'(IGNORE));
      chk("rd_addr_wrap", 32'(reg_addr), 32'h00);
      chk("rd_strobe_count", 32'(rd_cnt - base_rd), 32'd2);
      chk("rd_no_wr", 32'(wr_cnt - base_wr), 32'd0);
      i2c_stop(); tick(20);
      chk("rd_busy_low", 32'(busy), 32'd0);

      // STOP after 4 data bits
      base_wr = wr_cnt;
      i2c_start();
      write_byte(8'h34, ack); chk("ab_ack_dev", 32'(ack), 32'd0);
      write_byte(8'h10, ack); chk("ab_ack_ptr", 32'(ack), 32'd0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop(); tick(20);
      chk("ab_no_wr", 32'(wr_cnt - base_wr), 32'd0);
      chk("ab_addr", 32'(reg_addr), 32'h10);
      chk("ab_state_idle", 32'(dut.state_q), 32'(IDLE));

      // SDA glitches while SCL high
      base_st = start_cnt;
      sda_m = 1'b0; tick(2); sda_m = 1'b1; tick(12);
      chk("gl_short_ignored", 32'(start_cnt - base_st), 32'd0);
      sda_m = 1'b0; tick(5); sda_m = 1'b1; tick(12);
      chk("gl_long_start", 32'(start_cnt - base_st), 32'd1);
      chk("gl_back_idle", 32'(dut.state_q), 32'(IDLE));

      // Reset while the target drives the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
      tick(q);
      chk("rs_driving_ack", 32'(sda_oe), 32'd1);
      rst = 1'b1; tick(1);
      chk("rs_sda_released", 32'(sda_oe), 32'd0);
      chk("rs_outputs", {22'd0, reg_addr, reg_wr_en, reg_rd_en}, 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      i2c_stop(); tick(20);

      // Full transaction after reset
      base_wr = wr_cnt;
      i2c_start();
      write_byte(8'h34, ack); chk("pr_ack_dev", 32'(ack), 32'd0);
      write_byte(8'h20, ack); chk("pr_ack_ptr", 32'(ack), 32'd0);
      write_byte(8'h3C, ack); chk("pr_ack_data", 32'(ack), 32'd0);
      i2c_stop(); tick(20);
      chk("pr_strobe_count", 32'(wr_cnt - base_wr), 32'd1);
      chk("pr_strobe", 32'(wr_log[base_wr]), 32'h203C);
      chk("pr_addr", 32'(reg_addr), 32'h21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
